// File: rtl/meteor_field_if.sv
// -----------------------------------------------------------------------------
// meteor_field_if
//   Bundles the game-control inputs and the meteorite field outputs that pass
//   between the game controller / spaceship side and meteor_field.
//
//   start        level, begins or restarts a game
//   player_die   collision flag from the spaceship module
//   enemy_x[4]   left edge of each meteorite slot
//   enemy_y[4]   top edge of each meteorite slot
//   enemy_size[4] side length of each meteorite slot
//   enemy_alive[4] slot is drawn and collidable
//   score        meteorites dodged, saturating
//   speed        current fall speed in pixels per frame
//   running      high while a game is in progress
//
//   master: the controller side (drives start/player_die, observes the field)
//   slave : meteor_field itself
// -----------------------------------------------------------------------------
interface meteor_field_if;
    logic        start;
    logic        player_die;
    logic [9:0]  enemy_x     [4];
    logic [9:0]  enemy_y     [4];
    logic [9:0]  enemy_size  [4];
    logic        enemy_alive [4];
    logic [15:0] score;
    logic [2:0]  speed;
    logic        running;

    modport master (
        output start, player_die,
        input  enemy_x, enemy_y, enemy_size, enemy_alive, score, speed, running
    );

    modport slave (
        input  start, player_die,
        output enemy_x, enemy_y, enemy_size, enemy_alive, score, speed, running
    );
endinterface

// File: rtl/meteor_field.sv
// -----------------------------------------------------------------------------
// meteor_field
//   Meteorite generator and mover. Owns four slots, spawns each at an
//   LFSR-chosen x position and size, moves live slots down by `speed` pixels
//   per frame, retires them at the bottom edge and counts them as score.
//   The field freezes when the spaceship reports a collision.
//
// Ports
//   frame_clk  frame-rate clock, the only clock
//   Reset_n    asynchronous active-low reset
//   bus        meteor_field_if.slave: start, player_die in; enemy_x/y/size/
//              alive, score, speed, running out (all registered)
//
// Build option
//   METEOR_SPEEDUP_EN  when defined, speed rises by one each time score
//                      crosses a multiple of 16, up to SPEED_MAX. Otherwise
//                      speed stays at its start value.
// -----------------------------------------------------------------------------
module meteor_field #(
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned X_OFFSET    = 32,
    parameter int unsigned SPEED_INIT  = 2,
    parameter int unsigned SPEED_MAX   = 6,
    parameter int unsigned RESPAWN_MIN = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          frame_clk,
    input  logic          Reset_n,
    meteor_field_if.slave bus
);
    // Cooldown must hold RESPAWN_MIN + 15 (the largest random retire delay).
    localparam int CD_W = $clog2(RESPAWN_MIN + 16 + 1);
    localparam logic [10:0] BOTTOM = 11'(SCREEN_H);
    // The start speed never exceeds the ceiling, even with odd parameter sets.
    localparam logic [2:0] SPEED_START =
        3'((SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic            lfsr_fb;
    logic [CD_W-1:0] cooldown [4];

    logic [CD_W-1:0] cd_dec   [4];
    logic [3:0]      retire;
    logic [3:0]      spawn;
    logic            spawn_taken;
    logic [2:0]      retire_cnt;
    logic [16:0]     score_sum;
    logic [15:0]     score_next;
    logic [9:0]      spawn_size;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    // One RUN frame worth of decisions, evaluated from the current registers.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        retire      = '0;
        spawn       = '0;
        spawn_taken = 1'b0;
        retire_cnt  = '0;
        for (int i = 0; i < 4; i++) begin
            cd_dec[i] = (cooldown[i] != '0) ? cooldown[i] - CD_W'(1) : '0;
            // 11-bit sum so a position near 1023 cannot wrap past the bottom.
            retire[i] = bus.enemy_alive[i] &&
                        (({1'b0, bus.enemy_y[i]} + {8'd0, bus.speed}) >= BOTTOM);
            // A dead slot whose cooldown reaches zero this frame may spawn;
            // spawn_taken is updated in loop order, giving the lowest index priority.
            if (!bus.enemy_alive[i] && cd_dec[i] == '0 && !spawn_taken) begin
                spawn[i]    = 1'b1;
                spawn_taken = 1'b1;
            end
            retire_cnt = retire_cnt + {2'b00, retire[i]};
        end
        score_sum  = {1'b0, bus.score} + {14'd0, retire_cnt};
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        case (lfsr[10:9])
            2'd0:    spawn_size = 10'd8;
            2'd1:    spawn_size = 10'd12;
            2'd2:    spawn_size = 10'd16;
            default: spawn_size = 10'd24;
        endcase
    end

`ifdef METEOR_SPEEDUP_EN
    localparam logic [2:0] SPEED_CAP = 3'(SPEED_MAX);
    logic [2:0] speed_next;

    // At most four retires per frame, so score crosses at most one multiple of 16.
    always_comb begin
        speed_next = bus.speed;
        if ((score_next[15:4] != bus.score[15:4]) && (bus.speed < SPEED_CAP))
            speed_next = bus.speed + 3'd1;
    end
`endif

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            bus.score   <= '0;
            bus.speed   <= SPEED_START;
            bus.running <= 1'b0;
            // NOTE: the slot arrays are ordinary flops, not a RAM, so they are reset like any other state.
            for (int i = 0; i < 4; i++) begin
                bus.enemy_x[i]     <= '0;
                bus.enemy_y[i]     <= '0;
                bus.enemy_size[i]  <= '0;
                bus.enemy_alive[i] <= 1'b0;
                cooldown[i]        <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            lfsr <= {lfsr[14:0], lfsr_fb};
            case (state)
                IDLE, FROZEN: begin
                    if (bus.start) begin
                        state       <= RUN;
                        bus.running <= 1'b1;
                        bus.score   <= '0;
                        bus.speed   <= SPEED_START;
                        for (int i = 0; i < 4; i++) begin
                            bus.enemy_alive[i] <= 1'b0;
                            cooldown[i]        <= CD_W'(RESPAWN_MIN + i);  // staggered spawns
                        end
                    end
                end
                RUN: begin
                    if (bus.player_die) begin
                        // Collision wins over any retire or spawn due this frame.
                        state       <= FROZEN;
                        bus.running <= 1'b0;
                    end else begin
                        bus.score <= score_next;
`ifdef METEOR_SPEEDUP_EN
                        bus.speed <= speed_next;
`endif
                        for (int i = 0; i < 4; i++) begin
                            if (retire[i]) begin
                                bus.enemy_alive[i] <= 1'b0;
                                cooldown[i] <= CD_W'(RESPAWN_MIN) + CD_W'(lfsr[15:12]);
                            end else if (bus.enemy_alive[i]) begin
                                bus.enemy_y[i] <= bus.enemy_y[i] + {7'd0, bus.speed};
                            end else if (spawn[i]) begin
                                bus.enemy_x[i]     <= 10'(X_OFFSET) + {1'b0, lfsr[8:0]};
                                bus.enemy_y[i]     <= '0;
                                bus.enemy_size[i]  <= spawn_size;
                                bus.enemy_alive[i] <= 1'b1;
                                cooldown[i]        <= '0;
                            end else begin
                                cooldown[i] <= cd_dec[i];
                            end
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.running <= 1'b0;
                end
            endcase
        end
    end
endmodule
